// File: rtl/aq_ifu_btb_pkg.sv
// rtl/aq_ifu_btb_pkg.sv - shared sizing and FSM encoding for the IFU BTB controller
package aq_ifu_btb_pkg;
    localparam int ENTRY_NUM  = 16;
    localparam int INV_GRP    = 4;
    localparam int ADDR_WIDTH = 16;
    localparam int GRP_NUM    = ENTRY_NUM / INV_GRP;
    localparam int CNT_W      = (GRP_NUM > 1) ? $clog2(GRP_NUM) : 1;
    localparam int IDX_W      = $clog2(ENTRY_NUM);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        INV  = 2'd2
    } btb_state_t;
endpackage

// File: rtl/aq_ifu_btb_victim.sv
// rtl/aq_ifu_btb_victim.sv - BTB victim selection: round-robin, or tree pseudo-LRU with AQ_IFU_BTB_PLRU_EN
module aq_ifu_btb_victim #(
    parameter int N  = 16,
    parameter int IW = $clog2(N)
) (
    input  logic          btb_entry_clk,
    input  logic          cpurst_b,
    input  logic          advance,
    input  logic          wr_touch_vld,
    input  logic [IW-1:0] wr_touch_idx,
    input  logic          rd_touch_vld,
    input  logic [IW-1:0] rd_touch_idx,
    input  logic          clear,
    output logic [N-1:0]  victim_oh
);
`ifdef AQ_IFU_BTB_PLRU_EN
    logic [N-2:0] tree;
    logic [N-2:0] tree_rd;
    logic [N-2:0] tree_nxt;
    logic [IW-1:0] vic_idx;
    logic          unused_adv;

    assign unused_adv = advance;

    // Each node on the touched path is pointed away from the touched leaf.
    function automatic logic [N-2:0] plru_touch(input logic [N-2:0] t, input logic [IW-1:0] idx);
        logic [N-2:0] r;
        int node;
        r    = t;
        node = 0;
        for (int l = 0; l < IW; l++) begin
            r[node] = ~idx[IW-1-l];
            node    = 2 * node + 1 + int'(idx[IW-1-l]);
        end
        return r;
    endfunction

    always_comb begin
        tree_rd  = rd_touch_vld ? plru_touch(tree, rd_touch_idx) : tree;
        tree_nxt = wr_touch_vld ? plru_touch(tree_rd, wr_touch_idx) : tree_rd;
    end

    always_ff @(posedge btb_entry_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            tree <= '0;
        end else if (clear) begin
            tree <= '0;
        end else begin
            tree <= tree_nxt;
        end
    end

    always_comb begin
        int node;
        node    = 0;
        vic_idx = '0;
        for (int l = 0; l < IW; l++) begin
            vic_idx[IW-1-l] = tree[node];
            node            = 2 * node + 1 + int'(tree[node]);
        end
        victim_oh          = '0;
        victim_oh[vic_idx] = 1'b1;
    end
`else
    logic [IW-1:0] ptr;
    logic          unused_touch;

    assign unused_touch = wr_touch_vld | rd_touch_vld | (|wr_touch_idx) | (|rd_touch_idx);

    always_ff @(posedge btb_entry_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            ptr <= '0;
        end else if (clear) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= ptr + IW'(1);
        end
    end

    assign victim_oh = N'(1) << ptr;
`endif
endmodule

// File: rtl/aq_ifu_btb_ctrl.sv
// rtl/aq_ifu_btb_ctrl.sv - IFU BTB update/invalidate sequencer; AQ_IFU_BTB_PLRU_EN selects PLRU replacement
module aq_ifu_btb_ctrl
    import aq_ifu_btb_pkg::*;
(
    input  logic                  btb_entry_clk,
    input  logic                  cpurst_b,
    input  logic                  cp0_ifu_btb_en,
    input  logic                  cp0_ifu_btb_inv,
    input  logic                  bru_upd_vld,
    input  logic [ADDR_WIDTH-1:0] bru_upd_tag,
    input  logic [ADDR_WIDTH-1:0] bru_upd_tgt,
    output logic                  bru_upd_rdy,
    input  logic [ENTRY_NUM-1:0]  btb_entry_wr_hit_x,
    input  logic [ENTRY_NUM-1:0]  btb_entry_rd_hit_x,
    input  logic                  ifu_btb_rd_vld,
    output logic [ADDR_WIDTH-1:0] btb_wr_acc_tag,
    output logic [ADDR_WIDTH-1:0] btb_upd_tag,
    output logic [ADDR_WIDTH-1:0] btb_upd_tgt,
    output logic [ENTRY_NUM-1:0]  btb_entry_upd_x,
    output logic [ENTRY_NUM-1:0]  btb_entry_updg_x,
    output logic [ENTRY_NUM-1:0]  btb_entry_clr_x,
    output logic [ENTRY_NUM-1:0]  btb_entry_clrg_x,
    output logic                  btb_inv_busy,
    output logic                  btb_inv_done
);
    btb_state_t            state;
    logic                  inv_pend;
    logic [ADDR_WIDTH-1:0] req_tag;
    logic [ADDR_WIDTH-1:0] req_tgt;
    logic [CNT_W-1:0]      inv_cnt;
    logic [ENTRY_NUM-1:0]  hit_oh;
    logic [ENTRY_NUM-1:0]  victim_oh;
    logic [ENTRY_NUM-1:0]  upd_oh;
    logic [ENTRY_NUM-1:0]  clr_oh;
    logic                  any_hit;
    logic                  inv_last;
    logic                  inv_start;
    logic [IDX_W-1:0]      wr_idx;
    logic                  rd_touch_vld;
    logic [IDX_W-1:0]      rd_touch_idx;

    assign bru_upd_rdy = (state == IDLE) && cp0_ifu_btb_en && !inv_pend;
    assign any_hit     = |btb_entry_wr_hit_x;
    assign hit_oh      = btb_entry_wr_hit_x & (~btb_entry_wr_hit_x + ENTRY_NUM'(1));
    assign upd_oh      = (state == WR) ? (any_hit ? hit_oh : victim_oh) : '0;
    assign inv_last    = (state == INV) && (inv_cnt == CNT_W'(GRP_NUM - 1));
    // A fresh pulse inside a sweep restarts it, so the aborted pass never reports done.
    assign inv_start   = ((state == IDLE) && inv_pend) || ((state == INV) && cp0_ifu_btb_inv);

    always_comb begin
        clr_oh = '0;
        if (state == INV) begin
            clr_oh[inv_cnt * INV_GRP +: INV_GRP] = '1;
        end
    end

    always_comb begin
        wr_idx = '0;
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            if (upd_oh[i]) wr_idx = IDX_W'(i);
        end
    end

`ifdef AQ_IFU_BTB_PLRU_EN
    assign rd_touch_vld = ifu_btb_rd_vld && (|btb_entry_rd_hit_x);
    always_comb begin
        rd_touch_idx = '0;
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            if (btb_entry_rd_hit_x[i]) rd_touch_idx = IDX_W'(i);
        end
    end
`else
    logic unused_rd;
    assign unused_rd    = ifu_btb_rd_vld | (|btb_entry_rd_hit_x);
    assign rd_touch_vld = 1'b0;
    assign rd_touch_idx = '0;
`endif

    aq_ifu_btb_victim #(.N(ENTRY_NUM)) u_victim (
        .btb_entry_clk (btb_entry_clk),
        .cpurst_b      (cpurst_b),
        .advance       ((state == WR) && !any_hit),
        .wr_touch_vld  (state == WR),
        .wr_touch_idx  (wr_idx),
        .rd_touch_vld  (rd_touch_vld),
        .rd_touch_idx  (rd_touch_idx),
        .clear         (btb_inv_done),
        .victim_oh     (victim_oh)
    );

    always_ff @(posedge btb_entry_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state    <= IDLE;
            inv_pend <= 1'b0;
            req_tag  <= '0;
            req_tgt  <= '0;
            inv_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (inv_pend) begin
                        state   <= INV;
                        inv_cnt <= '0;
                    end else if (bru_upd_vld && bru_upd_rdy) begin
                        state   <= WR;
                        req_tag <= bru_upd_tag;
                        req_tgt <= bru_upd_tgt;
                    end
                end
                WR: state <= IDLE;
                INV: begin
                    if (cp0_ifu_btb_inv) begin
                        inv_cnt <= '0;
                    end else if (inv_last) begin
                        state   <= IDLE;
                        inv_cnt <= '0;
                    end else begin
                        inv_cnt <= inv_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
            if (inv_start) begin
                inv_pend <= 1'b0;
            end else if (cp0_ifu_btb_inv) begin
                inv_pend <= 1'b1;
            end
        end
    end

    assign btb_wr_acc_tag   = req_tag;
    assign btb_upd_tag      = req_tag;
    assign btb_upd_tgt      = req_tgt;
    assign btb_entry_upd_x  = upd_oh;
    assign btb_entry_updg_x = upd_oh;
    assign btb_entry_clr_x  = clr_oh;
    assign btb_entry_clrg_x = clr_oh;
    assign btb_inv_busy     = inv_pend || (state == INV);
    assign btb_inv_done     = inv_last && !cp0_ifu_btb_inv;
endmodule

// File: tb/tb_aq_ifu_btb_ctrl.sv
// tb/tb_aq_ifu_btb_ctrl.sv - self-checking bench for aq_ifu_btb_ctrl against a cycle-level reference model
module tb_aq_ifu_btb_ctrl;
    logic        clk = 1'b0;
    logic        cpurst_b;
    logic        en, inv, vld, rvld;
    logic [15:0] tag, tgt, whit, rhit;
    logic        rdy, busy, done;
    logic [15:0] acc_tag, upd_tag, upd_tgt, upd_x, updg_x, clr_x, clrg_x;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit          m_wr;
    bit          m_req;
    int          m_sweep;
    int          m_vic;
    logic [15:0] m_tag, m_tgt;

    // samples from the most recent cycle
    logic [15:0] s_upd, s_clr, s_acc, s_tgt;
    logic        s_rdy, s_busy, s_done;
    int          ndone;

    always #5 clk = ~clk;

    aq_ifu_btb_ctrl dut (
        .btb_entry_clk      (clk),
        .cpurst_b           (cpurst_b),
        .cp0_ifu_btb_en     (en),
        .cp0_ifu_btb_inv    (inv),
        .bru_upd_vld        (vld),
        .bru_upd_tag        (tag),
        .bru_upd_tgt        (tgt),
        .bru_upd_rdy        (rdy),
        .btb_entry_wr_hit_x (whit),
        .btb_entry_rd_hit_x (rhit),
        .ifu_btb_rd_vld     (rvld),
        .btb_wr_acc_tag     (acc_tag),
        .btb_upd_tag        (upd_tag),
        .btb_upd_tgt        (upd_tgt),
        .btb_entry_upd_x    (upd_x),
        .btb_entry_updg_x   (updg_x),
        .btb_entry_clr_x    (clr_x),
        .btb_entry_clrg_x   (clrg_x),
        .btb_inv_busy       (busy),
        .btb_inv_done       (done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lowest(input logic [15:0] v);
        for (int i = 0; i < 16; i++) begin
            if (v[i]) return 16'(1) << i;
        end
        return 16'h0;
    endfunction

    task automatic model_reset();
        m_wr = 0; m_req = 0; m_sweep = -1; m_vic = 0; m_tag = 0; m_tgt = 0;
    endtask

    // Entered at posedge+1 with inputs already set; checks, advances model, returns at next posedge+1.
    task automatic cycle();
        logic [15:0] e_upd, e_clr;
        logic        e_rdy, e_busy, e_done, idle;
        #3;
        idle   = !m_wr && (m_sweep < 0);
        e_rdy  = idle && en && !m_req;
        e_busy = m_req || (m_sweep >= 0);
        e_upd  = m_wr ? ((whit != 0) ? lowest(whit) : (16'(1) << m_vic)) : 16'h0;
        e_clr  = (m_sweep >= 0) ? (16'h000F << (4 * m_sweep)) : 16'h0;
        e_done = (m_sweep == 3) && !inv;
        chk("rdy", rdy, e_rdy);
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        chk("upd_x", upd_x, e_upd);
        chk("updg_x", updg_x, e_upd);
        chk("clr_x", clr_x, e_clr);
        chk("clrg_x", clrg_x, e_clr);
        chk("acc_tag", acc_tag, m_tag);
        chk("upd_tag", upd_tag, m_tag);
        chk("upd_tgt", upd_tgt, m_tgt);
        chk("upd_clr_excl", upd_x & clr_x, 0);
        s_upd = upd_x; s_clr = clr_x; s_acc = acc_tag; s_tgt = upd_tgt;
        s_rdy = rdy; s_busy = busy; s_done = done;
        if (m_wr) begin
            if (whit == 0) m_vic = (m_vic + 1) % 16;
            m_wr = 0;
            if (inv) m_req = 1;
        end else if (m_sweep >= 0) begin
            if (inv) m_sweep = 0;
            else if (m_sweep == 3) begin m_sweep = -1; m_vic = 0; end
            else m_sweep++;
        end else if (m_req) begin
            m_sweep = 0;
            m_req   = 0;
        end else begin
            if (vld && e_rdy) begin m_wr = 1; m_tag = tag; m_tgt = tgt; end
            if (inv) m_req = 1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        cpurst_b = 1'b0; en = 1'b1; inv = 1'b0; vld = 1'b0; rvld = 1'b0;
        tag = '0; tgt = '0; whit = '0; rhit = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy", rdy, 1);
        chk("rst_upd", upd_x, 0);
        chk("rst_clr", clr_x, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tag", acc_tag, 0);
        @(negedge clk) cpurst_b = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 3; i++) begin
            vld = 1; tag = 16'(i + 1) << 12; tgt = 16'h0100 + 16'(i);
            cycle();
            chk("fill_acc_rdy", s_rdy, 1);
            vld = 0;
            cycle();
            chk("fill_upd", s_upd, 16'(1) << i);
            chk("fill_wr_rdy", s_rdy, 0);
            chk("fill_tag", s_acc, 16'(i + 1) << 12);
        end
        chk("vic_after_fill", m_vic, 3);

        vld = 1; tag = 16'h2000; tgt = 16'hBEEF;
        cycle();
        vld = 0; whit = 16'h0002;
        cycle();
        chk("hit_upd", s_upd, 16'h0002);
        chk("hit_tgt", s_tgt, 16'hBEEF);
        chk("vic_after_hit", m_vic, 3);

        vld = 1; tag = 16'h4000; whit = 0;
        cycle();
        vld = 0; whit = 16'h0028;
        cycle();
        chk("dual_hit_upd", s_upd, 16'h0008);
        whit = 0;

        vld = 1; tag = 16'h5000;
        cycle();
        vld = 0;
        cycle();
        chk("miss_vic3", s_upd, 16'h0008);

        vld = 1; tag = 16'h6000;
        cycle();
        vld = 0; inv = 1;
        cycle();
        inv = 0;
        chk("wr_with_inv_upd", s_upd, 16'h0010);
        chk("wr_with_inv_busy", s_busy, 0);
        cycle();
        chk("pend_busy", s_busy, 1);
        chk("pend_rdy", s_rdy, 0);
        chk("pend_clr", s_clr, 0);
        for (int g = 0; g < 4; g++) begin
            cycle();
            chk("sweep_clr", s_clr, 16'h000F << (4 * g));
            chk("sweep_done", s_done, g == 3);
            chk("sweep_busy", s_busy, 1);
            chk("sweep_rdy", s_rdy, 0);
        end
        cycle();
        chk("post_sweep_busy", s_busy, 0);
        chk("post_sweep_rdy", s_rdy, 1);

        inv = 1;
        cycle();
        inv = 0;
        cycle();
        cycle();
        chk("rs_g0", s_clr, 16'h000F);
        inv = 1;
        cycle();
        inv = 0;
        chk("rs_g1", s_clr, 16'h00F0);
        chk("rs_abort_done", s_done, 0);
        ndone = 0;
        for (int g = 0; g < 4; g++) begin
            cycle();
            chk("rs_clr", s_clr, 16'h000F << (4 * g));
            if (s_done) ndone++;
        end
        chk("rs_done_cnt", ndone, 1);
        chk("rs_last_done", s_done, 1);

        for (int i = 0; i < 17; i++) begin
            vld = 1; tag = 16'($urandom); tgt = 16'($urandom);
            cycle();
            vld = 0;
            cycle();
            if (i == 15) chk("miss_entry15", s_upd, 16'h8000);
            if (i == 16) chk("miss_wrap", s_upd, 16'h0001);
        end

        inv = 1;
        cycle();
        inv = 0;
        cycle();
        cycle();
        chk("arst_pre_clr", clr_x, 16'h00F0);
        cpurst_b = 1'b0;
        #2;
        chk("arst_clr", clr_x, 0);
        chk("arst_busy", busy, 0);
        chk("arst_rdy", rdy, 1);
        chk("arst_tag", acc_tag, 0);
        model_reset();
        @(negedge clk) cpurst_b = 1'b1;
        @(posedge clk);
        #1;

        for (int c = 0; c < 3000; c++) begin
            en   = ($urandom_range(0, 7) != 0);
            inv  = !inv && ($urandom_range(0, 24) == 0);
            vld  = 1'($urandom_range(0, 1));
            tag  = 16'($urandom);
            tgt  = 16'($urandom);
            rvld = 1'($urandom_range(0, 1));
            rhit = 16'($urandom);
            case ($urandom_range(0, 3))
                0, 1:    whit = 16'h0;
                2:       whit = 16'(1) << $urandom_range(0, 15);
                default: whit = 16'($urandom) & 16'($urandom);
            endcase
            cycle();
        end
        inv = 0; vld = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
